// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake bundle (start,a,b,bin in; busy,done,diff,bout out) with master/slave views
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic bin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic bout;
  modport master(output start, a, b, bin, input busy, done, diff, bout);
  modport slave(input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b-bin, LSB first, one bit per clk; ports clk, rst_n (async low), bus (start/a/b/bin -> busy/done/diff/bout)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] ra, rb, sr;
  logic [CW-1:0] cnt;
  logic br, d, bn;
  assign d = ra[0] ^ rb[0] ^ br;
  assign bn = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      sr <= '0;
      br <= 1'b0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.start && state != SHIFT) begin
        ra <= bus.a;
        rb <= bus.b;
        br <= bus.bin;
        cnt <= '0;
        state <= SHIFT;
        bus.busy <= 1'b1;
      end else if (state == DONE) begin
        state <= IDLE;
        bus.busy <= 1'b0;
      end else if (state == SHIFT) begin
        sr <= {d, sr[WIDTH-1:1]};
        ra <= ra >> 1;
        rb <= rb >> 1;
        br <= bn;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          bus.diff <= {d, sr[WIDTH-1:1]};
          bus.bout <= bn;
          bus.done <= 1'b1;
          state <= DONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive checks of serial_subtractor at WIDTH 8 and 3 against a cycle-level arithmetic model
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  serial_subtractor_if #(8) b8();
  serial_subtractor_if #(3) b3();
  serial_subtractor #(.WIDTH(8)) dut8(.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  serial_subtractor #(.WIDTH(3)) dut3(.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  function automatic logic [31:0] ref_diff(int w, int a, int b, int bin);
    return 32'((a - b - bin) & ((1 << w) - 1));
  endfunction
  function automatic logic ref_bout(int a, int b, int bin);
    return a < b + bin;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  int left8, left3;
  logic [31:0] pd8, pd3, md8, md3;
  logic pb8, pb3, mb8, mb3;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left8 <= 0;
      md8 <= 0;
      mb8 <= 0;
    end else begin
      if (left8 == 2) begin
        md8 <= pd8;
        mb8 <= pb8;
      end
      if (b8.start && left8 <= 1) begin
        left8 <= 9;
        pd8 <= ref_diff(8, int'(b8.a), int'(b8.b), int'(b8.bin));
        pb8 <= ref_bout(int'(b8.a), int'(b8.b), int'(b8.bin));
      end else if (left8 > 0) left8 <= left8 - 1;
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left3 <= 0;
      md3 <= 0;
      mb3 <= 0;
    end else begin
      if (left3 == 2) begin
        md3 <= pd3;
        mb3 <= pb3;
      end
      if (b3.start && left3 <= 1) begin
        left3 <= 4;
        pd3 <= ref_diff(3, int'(b3.a), int'(b3.b), int'(b3.bin));
        pb3 <= ref_bout(int'(b3.a), int'(b3.b), int'(b3.bin));
      end else if (left3 > 0) left3 <= left3 - 1;
    end
  end
  always @(negedge clk) begin
    chk("busy8", 32'(b8.busy), 32'(left8 != 0));
    chk("done8", 32'(b8.done), 32'(left8 == 1));
    chk("diff8", 32'(b8.diff), md8);
    chk("bout8", 32'(b8.bout), 32'(mb8));
    chk("busy3", 32'(b3.busy), 32'(left3 != 0));
    chk("done3", 32'(b3.done), 32'(left3 == 1));
    chk("diff3", 32'(b3.diff), md3);
    chk("bout3", 32'(b3.bout), 32'(mb3));
  end
  function automatic logic done_of(int w);
    return w == 8 ? b8.done : b3.done;
  endfunction
  task automatic drive(int w, logic s, int a, int b, int bin);
    if (w == 8) begin
      b8.start = s;
      b8.a = 8'(a);
      b8.b = 8'(b);
      b8.bin = bin[0];
    end else begin
      b3.start = s;
      b3.a = 3'(a);
      b3.b = 3'(b);
      b3.bin = bin[0];
    end
  endtask
  task automatic wait_done(int w, int from, output int n);
    n = from;
    while (!done_of(w) && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run(int w, int a, int b, int bin);
    int n;
    drive(w, 1'b1, a, b, bin);
    @(negedge clk);
    drive(w, 1'b0, 0, 0, 0);
    wait_done(w, 1, n);
    chk("latency", 32'(n), 32'(w + 1));
  endtask
  initial begin
    int n;
    drive(8, 1'b0, 0, 0, 0);
    drive(3, 1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(b8.busy), 0);
    chk("rst_diff", 32'(b8.diff), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("busy_pre", 32'(b8.busy), 0);
    drive(8, 1'b1, 8'h05, 8'h03, 0);
    @(negedge clk);
    drive(8, 1'b0, 0, 0, 0);
    chk("busy_next", 32'(b8.busy), 1);
    wait_done(8, 1, n);
    chk("latency_first", 32'(n), 9);
    chk("d_05_03", 32'(b8.diff), 32'h02);
    chk("b_05_03", 32'(b8.bout), 0);
    @(negedge clk);
    chk("busy_after", 32'(b8.busy), 0);
    run(8, 8'h03, 8'h05, 0);
    chk("d_03_05", 32'(b8.diff), 32'hFE);
    chk("b_03_05", 32'(b8.bout), 1);
    run(8, 8'h00, 8'h00, 1);
    chk("d_00_00_1", 32'(b8.diff), 32'hFF);
    chk("b_00_00_1", 32'(b8.bout), 1);
    run(8, 8'hFF, 8'hFF, 1);
    chk("d_FF_FF_1", 32'(b8.diff), 32'hFF);
    chk("b_FF_FF_1", 32'(b8.bout), 1);
    run(8, 8'h80, 8'h7F, 0);
    chk("d_80_7F", 32'(b8.diff), 32'h01);
    chk("b_80_7F", 32'(b8.bout), 0);
    @(negedge clk);
    drive(8, 1'b1, 8'h10, 8'h01, 0);
    @(negedge clk);
    drive(8, 1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    drive(8, 1'b1, 8'hAA, 8'h0B, 1);
    @(negedge clk);
    drive(8, 1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    drive(8, 1'b1, 8'h33, 8'h44, 0);
    @(negedge clk);
    drive(8, 1'b0, 0, 0, 0);
    chk("diff_hold", 32'(b8.diff), 32'h01);
    wait_done(8, 7, n);
    chk("latency_ign", 32'(n), 9);
    chk("d_10_01", 32'(b8.diff), 32'h0F);
    chk("b_10_01", 32'(b8.bout), 0);
    repeat (12) @(negedge clk);
    drive(8, 1'b1, 8'h20, 8'h01, 0);
    @(negedge clk);
    drive(8, 1'b1, 8'h01, 8'h02, 0);
    wait_done(8, 1, n);
    chk("latency_b2b1", 32'(n), 9);
    chk("d_20_01", 32'(b8.diff), 32'h1F);
    chk("b_20_01", 32'(b8.bout), 0);
    @(negedge clk);
    drive(8, 1'b0, 0, 0, 0);
    wait_done(8, 1, n);
    chk("gap_b2b", 32'(n), 9);
    chk("d_01_02", 32'(b8.diff), 32'hFF);
    chk("b_01_02", 32'(b8.bout), 1);
    @(negedge clk);
    drive(8, 1'b1, 8'h55, 8'h11, 0);
    @(negedge clk);
    drive(8, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(b8.busy), 0);
    chk("arst_done", 32'(b8.done), 0);
    chk("arst_diff", 32'(b8.diff), 0);
    chk("arst_bout", 32'(b8.bout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    run(8, 8'h9C, 8'h2D, 1);
    chk("d_9C_2D_1", 32'(b8.diff), 32'h6E);
    chk("b_9C_2D_1", 32'(b8.bout), 0);
    @(negedge clk);
    for (int i = 0; i < 128; i++) run(3, (i >> 4) & 7, (i >> 1) & 7, i & 1);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
